// File: rtl/ov7670_sccb_ctrl_pkg.sv
// Shared constants and types for the OV7670 SCCB configuration controller:
// SCCB write ID, table markers, OV7670 register addresses, FSM state and
// the 16-bit table entry layout.
package ov7670_sccb_ctrl_pkg;

  localparam int unsigned c_rom_addr_w_def = 6;
  localparam int unsigned c_frame_w        = 27;  // 3 phases x (8 data + 1 X)
  localparam int unsigned c_bit_w          = 5;

  localparam logic [7:0]  c_sccb_id    = 8'h42;
  localparam logic [15:0] c_end_marker = 16'hFFFF;
  localparam logic [7:0]  c_delay_addr = 8'hFF;

  localparam logic [7:0] c_reg_clkrc  = 8'h11;
  localparam logic [7:0] c_reg_com7   = 8'h12;
  localparam logic [7:0] c_reg_tslb   = 8'h3A;
  localparam logic [7:0] c_reg_com15  = 8'h40;
  localparam logic [7:0] c_reg_rgb444 = 8'h8C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } cfg_entry_t;

  // The ninth bit of each phase is the don't-care/ACK slot: SIOD released.
  function automatic logic is_ack_bit(input logic [c_bit_w-1:0] bit_idx);
    return (bit_idx == c_bit_w'(8)) || (bit_idx == c_bit_w'(17)) ||
           (bit_idx == c_bit_w'(26));
  endfunction

endpackage

// File: rtl/ov7670_sccb_ctrl_if.sv
// Control handshake and SCCB bus signals of the configuration controller.
// master: requester side (drives start/rgbmode, observes status and bus)
// slave : controller side
interface ov7670_sccb_ctrl_if #(
  parameter int unsigned c_nb_rom_addr = ov7670_sccb_ctrl_pkg::c_rom_addr_w_def
) ();

  logic                     start;
  logic                     rgbmode;
  logic                     busy;
  logic                     done;
  logic                     sioc;
  logic                     siod_out;
  logic                     siod_oe;
  logic [c_nb_rom_addr-1:0] cfg_idx;

  modport master (
    output start, rgbmode,
    input  busy, done, sioc, siod_out, siod_oe, cfg_idx
  );

  modport slave (
    input  start, rgbmode,
    output busy, done, sioc, siod_out, siod_oe, cfg_idx
  );

endinterface

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table, combinational lookup of {rgbmode, idx}.
// Ports: rgbmode (mode select), idx (entry index), entry_c ({reg_addr, reg_data}).
module ov7670_reg_rom
  import ov7670_sccb_ctrl_pkg::*;
#(
  parameter int unsigned c_nb_rom_addr = 6
) (
  input  logic                     rgbmode,
  input  logic [c_nb_rom_addr-1:0] idx,
  output cfg_entry_t               entry_c
);

  always_comb begin
    entry_c = cfg_entry_t'(c_end_marker);
    case (32'(idx))
      32'd0: entry_c = '{reg_addr: c_reg_com7,   reg_data: 8'h80};  // soft reset
      32'd1: entry_c = '{reg_addr: c_delay_addr, reg_data: 8'hF0};  // settle after reset
      32'd2: entry_c = '{reg_addr: c_reg_com7,   reg_data: rgbmode ? 8'h04 : 8'h00};
      32'd3: entry_c = '{reg_addr: c_reg_com15,  reg_data: rgbmode ? 8'hD0 : 8'hC0};
      32'd4: entry_c = '{reg_addr: c_reg_rgb444, reg_data: rgbmode ? 8'h02 : 8'h00};
      32'd5: entry_c = '{reg_addr: c_reg_clkrc,  reg_data: 8'h01};
      32'd6: entry_c = '{reg_addr: c_reg_tslb,   reg_data: 8'h04};
      default: entry_c = cfg_entry_t'(c_end_marker);
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_ctrl.sv
// OV7670 SCCB configuration controller: on start, walks the register table
// and issues 3-phase SCCB writes (ID 0x42, reg_addr, reg_data), honouring
// delay entries, until the end marker.
// Ports: clk, rst (async active-low), bus (slave modport: start, rgbmode,
// busy, done, sioc, siod_out, siod_oe, cfg_idx).
module ov7670_sccb_ctrl
  import ov7670_sccb_ctrl_pkg::*;
#(
  parameter int unsigned c_clk_freq     = 50_000_000,
  parameter int unsigned c_sccb_freq    = 100_000,
  parameter int unsigned c_delay_cycles = 50_000_000,
  parameter int unsigned c_nb_rom_addr  = 6
) (
  input  logic              clk,
  input  logic              rst,
  ov7670_sccb_ctrl_if.slave bus
);

  localparam int unsigned c_cnt_quarter = c_clk_freq / (4 * c_sccb_freq);
  localparam int unsigned c_qcnt_w = (c_cnt_quarter > 1) ? $clog2(c_cnt_quarter) : 1;
  localparam int unsigned c_dly_w  = (c_delay_cycles > 1) ? $clog2(c_delay_cycles) : 1;
  localparam logic [c_nb_rom_addr-1:0] c_idx_max = '1;

  state_t                   state_q, state_d;
  logic [1:0]               qph_q, qph_d;
  logic [c_bit_w-1:0]       bit_q, bit_d;
  logic [c_frame_w-1:0]     shift_q, shift_d;
  logic [c_qcnt_w-1:0]      qcnt_q, qcnt_d;
  logic [c_dly_w-1:0]       dly_q, dly_d;
  logic [c_nb_rom_addr-1:0] idx_q, idx_d;
  logic                     rgb_q, rgb_d;
  logic                     sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     tick_c, accept_c;
  cfg_entry_t               entry_c;

  ov7670_reg_rom #(.c_nb_rom_addr(c_nb_rom_addr)) u_rom (
    .rgbmode (rgb_q),
    .idx     (idx_q),
    .entry_c (entry_c)
  );

  assign tick_c   = busy_q && (qcnt_q == c_qcnt_w'(c_cnt_quarter - 1));
  assign accept_c = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      qph_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      qcnt_q  <= '0;
      dly_q   <= '0;
      idx_q   <= '0;
      rgb_q   <= 1'b0;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qph_q   <= qph_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      qcnt_q  <= qcnt_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      rgb_q   <= rgb_d;
      sioc_q  <= sioc_d;
      siod_q  <= siod_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; everything except start acceptance and DELAY advances on ticks.
  always_comb begin
    state_d = state_q;
    qph_d   = qph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    rgb_d   = rgb_q;
    qcnt_d  = '0;
    if (!accept_c && busy_q && !tick_c) qcnt_d = qcnt_q + c_qcnt_w'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          rgb_d   = bus.rgbmode;
          qph_d   = '0;
          bit_d   = '0;
        end
      end
      ST_FETCH: begin
        if (tick_c) begin
          if (entry_c == c_end_marker || idx_q == c_idx_max) begin
            state_d = ST_DONE;
          end else if (entry_c.reg_addr == c_delay_addr) begin
            state_d = ST_DELAY;
            dly_d   = '0;
          end else begin
            state_d = ST_START;
            qph_d   = '0;
            bit_d   = '0;
            shift_d = {c_sccb_id, 1'b1, entry_c.reg_addr, 1'b1, entry_c.reg_data, 1'b1};
          end
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (qph_q == 2'd1) begin
            state_d = ST_BITS;
            qph_d   = '0;
          end else begin
            qph_d = qph_q + 2'd1;
          end
        end
      end
      ST_BITS: begin
        if (tick_c) begin
          qph_d = qph_q + 2'd1;
          if (qph_q == 2'd3) begin
            shift_d = {shift_q[c_frame_w-2:0], 1'b0};
            if (bit_q == c_bit_w'(c_frame_w - 1)) begin
              state_d = ST_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + c_bit_w'(1);
            end
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (qph_q == 2'd2) begin
            state_d = ST_GAP;
            qph_d   = '0;
          end else begin
            qph_d = qph_q + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          qph_d = qph_q + 2'd1;
          if (qph_q == 2'd3) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + c_nb_rom_addr'(1);
          end
        end
      end
      ST_DELAY: begin
        if (dly_q == c_dly_w'(c_delay_cycles - 1)) begin
          state_d = ST_FETCH;
          idx_d   = idx_q + c_nb_rom_addr'(1);
        end else begin
          dly_d = dly_q + c_dly_w'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered alongside it.
  always_comb begin
    sioc_d = 1'b1;
    siod_d = 1'b1;
    oe_d   = 1'b0;
    busy_d = !(state_d == ST_IDLE || state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_START: begin
        oe_d   = 1'b1;
        siod_d = (qph_d == 2'd0);
      end
      ST_BITS: begin
        sioc_d = qph_d[1];
        siod_d = shift_d[c_frame_w-1];
        oe_d   = !is_ack_bit(bit_d);
      end
      ST_STOP: begin
        oe_d   = 1'b1;
        sioc_d = (qph_d != 2'd0);
        siod_d = (qph_d == 2'd2);
      end
      default: ;
    endcase
  end

  assign bus.sioc     = sioc_q;
  assign bus.siod_out = siod_q;
  assign bus.siod_oe  = oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_idx  = idx_q;

endmodule
